// File: rtl/hazard_detection_unit_if.sv
// ============================================================================
//  hazard_detection_unit_if
//  ID-stage hazard unit signal bundle: decoded ID fields, memory freeze and
//  the resulting stall / write-enable / bubble controls.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_detection_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_reg_write_i;
    logic              id_mem_read_i;
    logic              id_branch_i;
    logic              mem_busy_i;
    logic              stall_o;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              noop_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        output id_rd_i, id_reg_write_i, id_mem_read_i, id_branch_i, mem_busy_i,
        input  stall_o, pc_write_o, ifid_write_o, noop_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        input  id_rd_i, id_reg_write_i, id_mem_read_i, id_branch_i, mem_busy_i,
        output stall_o, pc_write_o, ifid_write_o, noop_o, stall_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/hazard_detection_unit.sv
// ============================================================================
//  hazard_detection_unit
//  Load-use / ID-branch stall generation for a 5-stage RISC-V pipeline.
//  Optional saturating stall counter enabled by macro HDU_STALL_CNT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detection_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    hazard_detection_unit_if.slave  bus
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              ld;
    } slot_t;

    slot_t ex_slot;
    slot_t mem_slot;
    slot_t ex_next;

    logic rs1_used;
    logic rs2_used;
    logic ex_match;
    logic mem_match;
    logic haz;

    always_comb begin
        rs1_used  = bus.id_valid_i & bus.id_use_rs1_i;
        rs2_used  = bus.id_valid_i & bus.id_use_rs2_i;
        ex_match  = ex_slot.v & ex_slot.rw & (ex_slot.rd != '0) &
                    ((rs1_used & (ex_slot.rd == bus.id_rs1_i)) |
                     (rs2_used & (ex_slot.rd == bus.id_rs2_i)));
        mem_match = mem_slot.v & mem_slot.rw & (mem_slot.rd != '0) &
                    ((rs1_used & (mem_slot.rd == bus.id_rs1_i)) |
                     (rs2_used & (mem_slot.rd == bus.id_rs2_i)));
        // Branches resolve in ID, so an EX producer of any kind and a MEM load
        // are both too late; ordinary consumers only wait on an EX load.
        haz = (!bus.id_branch_i & ex_match & ex_slot.ld) |
              ( bus.id_branch_i & ex_match) |
              ( bus.id_branch_i & mem_match & mem_slot.ld);
    end

    always_comb begin
        bus.stall_o      = 1'b0;
        bus.pc_write_o   = 1'b1;
        bus.ifid_write_o = 1'b1;
        bus.noop_o       = 1'b0;
        if (bus.mem_busy_i) begin
            bus.pc_write_o   = 1'b0;
            bus.ifid_write_o = 1'b0;
        end else if (haz) begin
            bus.stall_o      = 1'b1;
            bus.pc_write_o   = 1'b0;
            bus.ifid_write_o = 1'b0;
            bus.noop_o       = 1'b1;
        end
    end

    always_comb begin
        ex_next = '0;
        if (!haz && bus.id_valid_i) begin
            ex_next.v  = 1'b1;
            ex_next.rd = bus.id_rd_i;
            ex_next.rw = bus.id_reg_write_i;
            ex_next.ld = bus.id_mem_read_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_slot  <= '0;
            mem_slot <= '0;
        end else if (!bus.mem_busy_i) begin
            mem_slot <= ex_slot;
            ex_slot  <= ex_next;
        end
    end

`ifdef HDU_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (bus.stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire
